// File: rtl/inverter_pkg.sv
// Shared definitions for the inverter gate-drive path: state codes,
// state width and default timing constants.
package inverter_pkg;

  localparam int ST_W = 3;

  localparam logic [7:0] DEAD_CYC_DEF = 8'd20;
  localparam logic [7:0] MIN_ON_DEF   = 8'd40;

  typedef enum logic [ST_W-1:0] {
    IDLE   = 3'd0,
    DEAD_H = 3'd1,
    ON_H   = 3'd2,
    DEAD_L = 3'd3,
    ON_L   = 3'd4,
    FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser; RST_VAL is the value both flops take in
// reset, so an active-low pin can come up inactive.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage shift; only q is consumed downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_deadtime.sv
// Complementary half-bridge gate driver: dead time on every transition,
// minimum on-time per gate, latched external fault with explicit clear.
module gate_deadtime
  import inverter_pkg::*;
#(
  parameter logic [7:0] DEAD_CYC = DEAD_CYC_DEF,
  parameter logic [7:0] MIN_ON   = MIN_ON_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sin,
  input  logic            en,
  input  logic            fault_n,
  input  logic            clr,
  output logic            gate_h,
  output logic            gate_l,
  output logic            fault,
  output logic [ST_W-1:0] st
);

  localparam logic [7:0] DEAD_LAST = DEAD_CYC - 8'd1;
  localparam logic [7:0] ON_LAST   = MIN_ON - 8'd1;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       fault_s;

  sync2 #(.RST_VAL(1'b1)) u_fault_sync (
    .clk (clk),
    .rst (rst),
    .d   (fault_n),
    .q   (fault_s)
  );

  // state and phase counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state: fault beats enable beats normal sequencing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!fault_s) begin
      state_nxt = FAULT;
      cnt_nxt   = 8'd0;
    end else if (state == FAULT) begin
      cnt_nxt = 8'd0;
      if (clr) state_nxt = IDLE;
    end else if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = sin ? DEAD_H : DEAD_L;
          cnt_nxt   = 8'd0;
        end
        DEAD_H: begin
          if (!sin) begin
            state_nxt = DEAD_L;           // command reversed: restart dead time
            cnt_nxt   = 8'd0;
          end else if (cnt == DEAD_LAST) begin
            state_nxt = ON_H;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        DEAD_L: begin
          if (sin) begin
            state_nxt = DEAD_H;
            cnt_nxt   = 8'd0;
          end else if (cnt == DEAD_LAST) begin
            state_nxt = ON_L;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        ON_H: begin
          // sin is only looked at once min on-time is met; earlier lows are ignored
          if (cnt == ON_LAST) begin
            if (!sin) begin
              state_nxt = DEAD_L;
              cnt_nxt   = 8'd0;
            end
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        ON_L: begin
          if (cnt == ON_LAST) begin
            if (sin) begin
              state_nxt = DEAD_H;
              cnt_nxt   = 8'd0;
            end
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        default: begin
          // unused codes are treated as a fault
          state_nxt = FAULT;
          cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // outputs decoded straight from the registered state (drops on async reset)
  always_comb begin
    gate_h = (state == ON_H);
    gate_l = (state == ON_L);
    fault  = (state == FAULT);
    st     = state;
  end

endmodule
